// File: rtl/dump_ctrl_pkg.sv
// Shared state encodings and width defaults for the dump window controller.
package dump_ctrl_pkg;

  localparam int unsigned FRAME_W_DEF = 32;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitLoad = 3'd1,
    StArmed    = 3'd2,
    StDumping  = 3'd3,
    StDone     = 3'd4
  } dump_state_e;

endpackage

// File: rtl/dump_edge.sv
// Single-register edge detector; edges are suppressed on the first cycle after reset.
module dump_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic prev_q;
  logic primed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      prev_q   <= din;
      primed_q <= 1'b1;
    end
  end

  assign rise = primed_q & ~prev_q & din;
  assign fall = primed_q & prev_q & ~din;

endmodule

// File: rtl/dump_window_ctrl.sv
// Frame-counted capture window controller. Optional DUMP_LOADWAIT_EN holds arming
// until a ROM download finishes and aborts the window when a new download starts.
module dump_window_ctrl
  import dump_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_W   = FRAME_W_DEF,
  parameter int unsigned GUARD_CYC = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vs,
  input  logic               downloading,
  input  logic [FRAME_W-1:0] start_frame,
  input  logic [FRAME_W-1:0] stop_frame,
  input  logic               deep,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               dump_en,
  output logic               dump_deep,
  output logic               dump_start,
  output logic               dump_stop,
  output logic [2:0]         state
);

  localparam logic [31:0] GuardLast = (GUARD_CYC == 0) ? 32'd0 : 32'(GUARD_CYC - 1);

  logic vs_rise, vs_fall, dl_rise, dl_fall;
  logic abort, load_done;

  dump_edge u_vs_edge (.clk(clk), .rst(rst), .din(vs), .rise(vs_rise), .fall(vs_fall));
  dump_edge u_dl_edge (.clk(clk), .rst(rst), .din(downloading), .rise(dl_rise), .fall(dl_fall));

`ifdef DUMP_LOADWAIT_EN
  localparam dump_state_e GuardNext = StWaitLoad;
  assign abort     = dl_rise;
  assign load_done = dl_fall;
  logic unused_edges;
  assign unused_edges = vs_rise;
`else
  localparam dump_state_e GuardNext = StArmed;
  assign abort     = 1'b0;
  assign load_done = 1'b0;
  logic unused_edges;
  assign unused_edges = vs_rise ^ dl_rise ^ dl_fall;
`endif

  dump_state_e        state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] start_q, start_d, stop_q, stop_d;
  logic [31:0]        guard_q, guard_d;
  logic               en_q, en_d, deep_q, deep_d;
  logic               start_p_q, start_p_d, stop_p_q, stop_p_d;

  always_comb begin
    state_d   = state_q;
    frame_d   = vs_fall ? frame_q + FRAME_W'(1) : frame_q;
    start_d   = start_q;
    stop_d    = stop_q;
    guard_d   = guard_q;
    en_d      = en_q;
    deep_d    = deep_q;
    start_p_d = 1'b0;
    stop_p_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (guard_q == GuardLast) begin
          state_d = GuardNext;
          start_d = start_frame;
          stop_d  = stop_frame;
        end else begin
          guard_d = guard_q + 32'd1;
        end
      end
      StWaitLoad: begin
        state_d = load_done ? StArmed : StWaitLoad;
`ifndef DUMP_LOADWAIT_EN
        state_d = StIdle;
`endif
      end
      StArmed: begin
        if (abort) begin
          state_d = StWaitLoad;
        end else if (vs_fall && frame_q == start_q) begin
          state_d   = StDumping;
          start_p_d = 1'b1;
          en_d      = 1'b1;
          deep_d    = deep;
        end
      end
      StDumping: begin
        // Abort takes priority over a coincident close; either way one stop pulse.
        if (abort || (vs_fall && stop_q != '0 && frame_q == stop_q)) begin
          state_d  = abort ? StWaitLoad : StDone;
          en_d     = 1'b0;
          stop_p_d = 1'b1;
        end
      end
      StDone: ;
      default: begin
        state_d = StIdle;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      guard_q   <= 32'd0;
      en_q      <= 1'b0;
      deep_q    <= 1'b0;
      start_p_q <= 1'b0;
      stop_p_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      guard_q   <= guard_d;
      en_q      <= en_d;
      deep_q    <= deep_d;
      start_p_q <= start_p_d;
      stop_p_q  <= stop_p_d;
    end
  end

  assign frame_cnt  = frame_q;
  assign dump_en    = en_q;
  assign dump_deep  = deep_q;
  assign dump_start = start_p_q;
  assign dump_stop  = stop_p_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Directed bench: a 32-bit and a 4-bit controller share clock, reset, vs and downloading.
module tb_dump_window_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b0;
  logic        downloading = 1'b0;
  logic [31:0] start_a = 32'd0, stop_a = 32'd0;
  logic        deep_a = 1'b0;
  logic [3:0]  start_b = 4'd0, stop_b = 4'd0;
  logic        deep_b = 1'b1;

  logic [31:0] cnt_a;
  logic        en_a, ddeep_a, dstart_a, dstop_a;
  logic [2:0]  st_a;
  logic [3:0]  cnt_b;
  logic        en_b, ddeep_b, dstart_b, dstop_b;
  logic [2:0]  st_b;

  dump_window_ctrl #(.FRAME_W(32), .GUARD_CYC(10)) dut_a (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .start_frame(start_a), .stop_frame(stop_a), .deep(deep_a),
    .frame_cnt(cnt_a), .dump_en(en_a), .dump_deep(ddeep_a),
    .dump_start(dstart_a), .dump_stop(dstop_a), .state(st_a)
  );

  dump_window_ctrl #(.FRAME_W(4), .GUARD_CYC(10)) dut_b (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .start_frame(start_b), .stop_frame(stop_b), .deep(deep_b),
    .frame_cnt(cnt_b), .dump_en(en_b), .dump_deep(ddeep_b),
    .dump_start(dstart_b), .dump_stop(dstop_b), .state(st_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sa_cnt = 0, pa_cnt = 0, sb_cnt = 0, pb_cnt = 0;

  always @(negedge clk) begin
    if (dstart_a) sa_cnt++;
    if (dstop_a)  pa_cnt++;
    if (dstart_b) sb_cnt++;
    if (dstop_b)  pb_cnt++;
  end

  typedef struct {
    logic [31:0] cnt_a;
    logic        en_a;
    logic [2:0]  st_a;
    logic [3:0]  cnt_b;
    logic        en_b;
    logic [2:0]  st_b;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    tick(3);
    vs = 1'b0;
    tick(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vs  = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  int snap;

  initial begin
    tbl[0]  = '{32'd1,  1'b0, 3'd2, 4'd1,  1'b0, 3'd2};
    tbl[1]  = '{32'd2,  1'b0, 3'd2, 4'd2,  1'b0, 3'd2};
    tbl[2]  = '{32'd3,  1'b0, 3'd2, 4'd3,  1'b0, 3'd2};
    tbl[3]  = '{32'd4,  1'b1, 3'd3, 4'd4,  1'b0, 3'd2};
    tbl[4]  = '{32'd5,  1'b1, 3'd3, 4'd5,  1'b0, 3'd2};
    tbl[5]  = '{32'd6,  1'b1, 3'd3, 4'd6,  1'b0, 3'd2};
    tbl[6]  = '{32'd7,  1'b0, 3'd4, 4'd7,  1'b0, 3'd2};
    tbl[7]  = '{32'd8,  1'b0, 3'd4, 4'd8,  1'b0, 3'd2};
    tbl[8]  = '{32'd9,  1'b0, 3'd4, 4'd9,  1'b0, 3'd2};
    tbl[9]  = '{32'd10, 1'b0, 3'd4, 4'd10, 1'b0, 3'd2};
    tbl[10] = '{32'd11, 1'b0, 3'd4, 4'd11, 1'b0, 3'd2};
    tbl[11] = '{32'd12, 1'b0, 3'd4, 4'd12, 1'b0, 3'd2};
    tbl[12] = '{32'd13, 1'b0, 3'd4, 4'd13, 1'b0, 3'd2};
    tbl[13] = '{32'd14, 1'b0, 3'd4, 4'd14, 1'b0, 3'd2};
    tbl[14] = '{32'd15, 1'b0, 3'd4, 4'd15, 1'b0, 3'd2};
    tbl[15] = '{32'd16, 1'b0, 3'd4, 4'd0,  1'b1, 3'd3};
    tbl[16] = '{32'd17, 1'b0, 3'd4, 4'd1,  1'b1, 3'd3};
    tbl[17] = '{32'd18, 1'b0, 3'd4, 4'd2,  1'b0, 3'd4};

    // Phase 1: a opens at 3 / closes at 6; b wraps, opens at 15, closes at 1.
    start_a = 32'd3; stop_a = 32'd6; deep_a = 1'b1;
    start_b = 4'd15; stop_b = 4'd1;
    do_reset();
    chk("rst_state_a", 32'(st_a), 32'd0);
    chk("rst_cnt_a", cnt_a, 32'd0);
    chk("rst_outs_a", {28'd0, en_a, ddeep_a, dstart_a, dstop_a}, 32'd0);
    tick(9);
    chk("guard_hold", 32'(st_a), 32'd0);
    tick(1);
    chk("guard_armed", 32'(st_a), 32'd2);
    chk("guard_armed_b", 32'(st_b), 32'd2);
    start_a = 32'd0;  // latched value 3 must still apply
    for (int i = 0; i < 18; i++) begin
      if (i == 3) begin
        vs = 1'b1;
        tick(3);
        vs = 1'b0;
        chk("start_not_early", 32'(dstart_a), 32'd0);
        tick(1);
        chk("start_pulse_hi", 32'(dstart_a), 32'd1);
        tick(1);
        chk("start_pulse_lo", 32'(dstart_a), 32'd0);
        tick(1);
      end else begin
        vs_pulse();
      end
      chk($sformatf("f%0d_cnt_a", i + 1), cnt_a, tbl[i].cnt_a);
      chk($sformatf("f%0d_en_a", i + 1), 32'(en_a), 32'(tbl[i].en_a));
      chk($sformatf("f%0d_st_a", i + 1), 32'(st_a), 32'(tbl[i].st_a));
      chk($sformatf("f%0d_cnt_b", i + 1), 32'(cnt_b), 32'(tbl[i].cnt_b));
      chk($sformatf("f%0d_en_b", i + 1), 32'(en_b), 32'(tbl[i].en_b));
      chk($sformatf("f%0d_st_b", i + 1), 32'(st_b), 32'(tbl[i].st_b));
      if (i == 3) begin
        deep_a = 1'b0;
        stop_a = 32'd5;
      end
    end
    chk("deep_held", 32'(ddeep_a), 32'd1);
    chk("starts_a", 32'(sa_cnt), 32'd1);
    chk("stops_a", 32'(pa_cnt), 32'd1);
    chk("starts_b", 32'(sb_cnt), 32'd1);
    chk("stops_b", 32'(pb_cnt), 32'd1);

    // Phase 2: a never closes; b has start == stop and closes only after the wrap.
    start_a = 32'd2; stop_a = 32'd0; deep_a = 1'b0;
    start_b = 4'd2;  stop_b = 4'd2;
    do_reset();
    tick(12);
    for (int k = 1; k <= 23; k++) begin
      vs_pulse();
      if (k == 2) chk("p2_en_a_closed", 32'(en_a), 32'd0);
      if (k == 3) begin
        chk("p2_en_a_open", 32'(en_a), 32'd1);
        chk("p2_en_b_open", 32'(en_b), 32'd1);
      end
      if (k == 18) begin
        chk("p2_b_cnt_wrap", 32'(cnt_b), 32'd2);
        chk("p2_b_still_open", 32'(en_b), 32'd1);
      end
      if (k == 19) begin
        chk("p2_b_closed", 32'(en_b), 32'd0);
        chk("p2_b_done", 32'(st_b), 32'd4);
      end
`ifndef DUMP_LOADWAIT_EN
      if (k == 10) begin
        downloading = 1'b1;
        tick(3);
        downloading = 1'b0;
        tick(3);
        chk("p2_dl_ignored", 32'(st_a), 32'd3);
      end
`endif
    end
    chk("p2_cnt_a", cnt_a, 32'd23);
    chk("p2_en_a_held", 32'(en_a), 32'd1);
    chk("p2_st_a", 32'(st_a), 32'd3);
    chk("p2_deep_a", 32'(ddeep_a), 32'd0);

    // Asynchronous reset mid-window, checked before any clock edge.
    snap = pa_cnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_en", 32'(en_a), 32'd0);
    chk("arst_state", 32'(st_a), 32'd0);
    chk("arst_cnt", cnt_a, 32'd0);
    chk("arst_outs", {29'd0, ddeep_a, dstart_a, dstop_a}, 32'd0);
    tick(2);
    chk("arst_no_stop", 32'(pa_cnt), 32'(snap));
    rst = 1'b0;

`ifdef DUMP_LOADWAIT_EN
    // Phase 3: download gating and abort.
    start_a = 32'd0; stop_a = 32'd0; deep_a = 1'b0;
    downloading = 1'b1;
    do_reset();
    tick(5);
    downloading = 1'b0;
    tick(5);
    chk("lw_wait_after_guard", 32'(st_a), 32'd1);
    tick(10);
    downloading = 1'b1;
    tick(30);
    chk("lw_wait_c50", 32'(st_a), 32'd1);
    downloading = 1'b0;
    tick(1);
    chk("lw_armed", 32'(st_a), 32'd2);
    vs_pulse();
    chk("lw_dumping", 32'(st_a), 32'd3);
    chk("lw_en", 32'(en_a), 32'd1);
    snap = pa_cnt;
    downloading = 1'b1;
    tick(1);
    chk("lw_abort_pulse", 32'(dstop_a), 32'd1);
    chk("lw_abort_state", 32'(st_a), 32'd1);
    chk("lw_abort_en", 32'(en_a), 32'd0);
    tick(1);
    chk("lw_abort_pulse_lo", 32'(dstop_a), 32'd0);
    chk("lw_abort_count", 32'(pa_cnt), 32'(snap + 1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
